sseg_iobus_driver: RTL

Memory-mapped four-digit seven-segment display controller on the OTTER IOBUS. It sits downstream of the MCU's store path, beside the LED/switch ports in the board wrapper. It replaces software-driven `segs`/`an` writes with hardware multiplexing: firmware writes a 16-bit value and control bits once, and the block scans the digits autonomously. Optional sequential binary-to-BCD conversion allows decimal display.

---
 rtl/sseg_pkg.sv | 78 +++++++
 rtl/sseg_iobus_driver_bin2bcd.sv | 70 +++++++
 rtl/sseg_iobus_driver.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/sseg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sseg_pkg: shared constants, segment patterns and helpers for the display.   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package sseg_pkg;

    localparam logic [31:0] DATA_OFS = 32'h0000_0000;
    localparam logic [31:0] CTRL_OFS = 32'h0000_0004;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_LZB    = 1;
    localparam int CTRL_DP_LSB = 4;
    localparam int CTRL_DEC    = 8;
    localparam int CTRL_BUSY   = 15;

    // Active-low {G,F,E,D,C,B,A}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic {
        BCD_IDLE  = 1'b0,
        BCD_SHIFT = 1'b1
    } bcd_state_t;

    function automatic logic [6:0] digit_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = SEG_0;
            4'h1: s = SEG_1;
            4'h2: s = SEG_2;
            4'h3: s = SEG_3;
            4'h4: s = SEG_4;
            4'h5: s = SEG_5;
            4'h6: s = SEG_6;
            4'h7: s = SEG_7;
            4'h8: s = SEG_8;
            4'h9: s = SEG_9;
            4'hA: s = SEG_A;
            4'hB: s = SEG_B;
            4'hC: s = SEG_C;
            4'hD: s = SEG_D;
            4'hE: s = SEG_E;
            default: s = SEG_F;
        endcase
        return s;
    endfunction

    // True when digit i sits above the most significant nonzero digit of v.
    function automatic logic leading_zero(input logic [15:0] v, input logic [1:0] i);
        logic z;
        case (i)
            2'd1:    z = (v[15:4] == 12'h000);
            2'd2:    z = (v[15:8] == 8'h00);
            2'd3:    z = (v[15:12] == 4'h0);
            default: z = 1'b0;
        endcase
        return z;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sseg_iobus_driver_bin2bcd.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bin2bcd_seq: sequential double-dabble, one shift per clk, 16 shifts total.  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module bin2bcd_seq
    import sseg_pkg::*;
(
    input  logic        clk,
    input  logic        RST,
    input  logic        start,
    input  logic [15:0] bin,
    output logic        busy,
    output logic [15:0] bcd,
    output logic        ovf
);

    bcd_state_t  state, state_nxt;
    logic [3:0]  shift_cnt;
    logic [35:0] work;
    logic [35:0] work_nxt;

    // Five BCD digits so that values up to 65535 resolve; a nonzero fifth digit is overflow.
    function automatic logic [35:0] dabble(input logic [35:0] w);
        logic [35:0] t;
        t = w;
        for (int d = 0; d < 5; d++) begin
            if (t[16 + 4*d +: 4] >= 4'd5)
                t[16 + 4*d +: 4] = t[16 + 4*d +: 4] + 4'd3;
        end
        return {t[34:0], 1'b0};
    endfunction

    assign work_nxt = dabble(work);
    assign busy     = (state == BCD_SHIFT);

    always_ff @(posedge clk) begin
        if (RST) begin
            state     <= BCD_IDLE;
            shift_cnt <= 4'd0;
            work      <= 36'd0;
            bcd       <= 16'h0000;
            ovf       <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start) begin
                work      <= {20'd0, bin};
                shift_cnt <= 4'd0;
            end else if (state == BCD_SHIFT) begin
                work      <= work_nxt;
                shift_cnt <= shift_cnt + 4'd1;
                if (shift_cnt == 4'd15) begin
                    bcd <= work_nxt[31:16];
                    ovf <= |work_nxt[35:32];
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            BCD_IDLE:  if (start) state_nxt = BCD_SHIFT;
            BCD_SHIFT: if (!start && shift_cnt == 4'd15) state_nxt = BCD_IDLE;
            default:   state_nxt = BCD_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/sseg_iobus_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sseg_iobus_driver: IOBUS-mapped 4-digit 7-seg scanner; SSEG_BCD_EN adds DEC. |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module sseg_iobus_driver
    import sseg_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h1100_C010,
    parameter int          REFRESH_CNT = 50000
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [31:0] iobus_addr,
    input  logic [31:0] iobus_out,
    input  logic        iobus_wr,
    output logic [31:0] rd_data,
    output logic [7:0]  segs,
    output logic [3:0]  an
);

    localparam int CNT_W = (REFRESH_CNT > 1) ? $clog2(REFRESH_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CNT - 1);

    logic        wr_data, wr_ctrl;
    logic [15:0] data;
    logic        en, lzb;
    logic [3:0]  dp;
    logic        dec, busy, ovf;
    logic [15:0] bcd;

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx, idx_next;
    logic             term;
    logic [15:0]      src;

    logic [3:0] slot_nib;
    logic       slot_blank, slot_dash, slot_dp;
    logic       unused;

    assign wr_data = iobus_wr && (iobus_addr == BASE_ADDR + DATA_OFS);
    assign wr_ctrl = iobus_wr && (iobus_addr == BASE_ADDR + CTRL_OFS);
    assign unused  = ^{iobus_out[31:9], iobus_out[8], iobus_out[3:2]};

    always_ff @(posedge clk) begin
        if (RST) begin
            data <= 16'h0000;
            en   <= 1'b0;
            lzb  <= 1'b0;
            dp   <= 4'h0;
        end else begin
            if (wr_data)
                data <= iobus_out[15:0];
            if (wr_ctrl) begin
                en  <= iobus_out[CTRL_EN];
                lzb <= iobus_out[CTRL_LZB];
                dp  <= iobus_out[CTRL_DP_LSB +: 4];
            end
        end
    end

`ifdef SSEG_BCD_EN
    logic        bcd_start;
    logic [15:0] bcd_bin;

    always_ff @(posedge clk) begin
        if (RST)
            dec <= 1'b0;
        else if (wr_ctrl)
            dec <= iobus_out[CTRL_DEC];
    end

    // A DATA write converts the incoming value, not the stale register contents.
    assign bcd_start = wr_data || (wr_ctrl && iobus_out[CTRL_DEC]);
    assign bcd_bin   = wr_data ? iobus_out[15:0] : data;

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .RST   (RST),
        .start (bcd_start),
        .bin   (bcd_bin),
        .busy  (busy),
        .bcd   (bcd),
        .ovf   (ovf)
    );
`else
    assign dec  = 1'b0;
    assign busy = 1'b0;
    assign bcd  = 16'h0000;
    assign ovf  = 1'b0;
`endif

    always_comb begin
        rd_data = 32'h0000_0000;
        if (iobus_addr == BASE_ADDR + DATA_OFS)
            rd_data = {16'h0000, data};
        else if (iobus_addr == BASE_ADDR + CTRL_OFS)
            rd_data = {16'h0000, busy, 6'b000000, dec, dp, 2'b00, lzb, en};
    end

    assign term     = (cnt == CNT_LAST);
    assign idx_next = idx + 2'd1;
    assign src      = dec ? bcd : data;

    // The digit content is captured when the slot is entered, so a write in
    // the same cycle as the terminal count shows up from the following slot.
    always_ff @(posedge clk) begin
        if (RST) begin
            cnt        <= '0;
            idx        <= 2'd0;
            slot_nib   <= 4'h0;
            slot_blank <= 1'b0;
            slot_dash  <= 1'b0;
            slot_dp    <= 1'b0;
        end else if (term) begin
            cnt        <= '0;
            idx        <= idx_next;
            slot_nib   <= src[{idx_next, 2'b00} +: 4];
            slot_dash  <= dec && ovf;
            slot_blank <= lzb && !(dec && ovf) && leading_zero(src, idx_next);
            slot_dp    <= dp[idx_next];
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            an   <= 4'hF;
            segs <= 8'hFF;
        end else if (!en || slot_blank) begin
            an   <= 4'hF;
            segs <= {1'b1, SEG_BLANK};
        end else begin
            an   <= ~(4'b0001 << idx);
            segs <= {~slot_dp, slot_dash ? SEG_DASH : digit_decode(slot_nib)};
        end
    end

endmodule
`default_nettype wire
